imem_arbiter: RTL

Shares the single-port synchronous instruction memory between two requesters: the instruction fetch unit (read-only) and the program loader/debug port (read/write). It sits between those two masters and the memory macro. Each cycle it grants at most one access, tags it with its owner, and returns read data one cycle later on the owner's port. Arbitration is round-robin, with an optional loader lock for burst programming.

---
 rtl/imem_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Shares one single-port synchronous instruction memory between the fetch
// unit (read-only) and the loader/debug port (read/write). At most one access
// is granted per cycle. Read data returns one cycle later on the port of the
// master that issued the read.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   f_req, f_addr              fetch read request
//   f_gnt                      fetch accepted this cycle (combinational)
//   f_rvalid, f_rdata          fetch read data, one cycle after f_gnt
//   l_req, l_we, l_lock,
//   l_addr, l_wdata            loader request, write flag, lock request, address, data
//   l_gnt                      loader accepted this cycle (combinational)
//   l_rvalid, l_rdata          loader read data, one cycle after a granted read
//   m_en, m_we, m_addr,
//   m_wdata, m_rdata           memory macro interface
module imem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic                  l_lock,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  m_en,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {OWN_FETCH = 1'b0, OWN_LOADER = 1'b1} owner_t;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  owner_t           last_owner;
  owner_t           rd_owner;
  logic             rd_valid;
  lock_state_t      lock_state, lock_state_next;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;

  // Grant selection. While locked the loader owns the memory as long as it
  // keeps requesting; once it drops l_req the lock is void, so the normal
  // round-robin path lets a waiting fetch in during that same cycle.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (lock_state == LOCKED && l_req) begin
      l_gnt = 1'b1;
    end else if (f_req && l_req) begin
      if (last_owner == OWN_LOADER) f_gnt = 1'b1;
      else                          l_gnt = 1'b1;
    end else if (f_req) begin
      f_gnt = 1'b1;
    end else if (l_req) begin
      l_gnt = 1'b1;
    end
  end

  // Memory port steering; write data is a plain pass-through.
  always_comb begin
    m_en    = f_gnt | l_gnt;
    m_we    = l_gnt & l_we;
    m_addr  = l_gnt ? l_addr : f_addr;
    m_wdata = l_wdata;
  end

  // Lock next-state. The counter includes the grant that entered the lock;
  // the grant that brings it to MAX_LOCK releases the lock so the loader,
  // now last_owner, loses the next tie to fetch.
  always_comb begin
    lock_state_next = lock_state;
    lock_cnt_next   = lock_cnt;
    if (l_gnt) begin
      if (l_lock && lock_cnt != CNT_W'(MAX_LOCK - 1)) begin
        lock_state_next = LOCKED;
        lock_cnt_next   = lock_cnt + CNT_W'(1);
      end else begin
        lock_state_next = UNLOCKED;
        lock_cnt_next   = '0;
      end
    end else if (lock_state == LOCKED) begin
      lock_state_next = UNLOCKED;
      lock_cnt_next   = '0;
    end
  end

  // State registers: lock FSM, round-robin owner and read-return tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_state <= UNLOCKED;
      lock_cnt   <= '0;
      last_owner <= OWN_LOADER;
      rd_valid   <= 1'b0;
      rd_owner   <= OWN_FETCH;
    end else begin
      lock_state <= lock_state_next;
      lock_cnt   <= lock_cnt_next;
      if (l_gnt)      last_owner <= OWN_LOADER;
      else if (f_gnt) last_owner <= OWN_FETCH;
      rd_valid <= f_gnt | (l_gnt & ~l_we);
      rd_owner <= l_gnt ? OWN_LOADER : OWN_FETCH;
    end
  end

  // Read return: data is shared, the tag decides which port sees rvalid.
  always_comb begin
    f_rvalid = rd_valid && (rd_owner == OWN_FETCH);
    l_rvalid = rd_valid && (rd_owner == OWN_LOADER);
    f_rdata  = m_rdata;
    l_rdata  = m_rdata;
  end

endmodule
